// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler: round-robin scheduler that shares one ADC among NCH
// requesters. Each conversion runs grant -> mux settle -> sample -> convert
// -> result. The result carries the channel number.
module adc_conv_scheduler #(
    parameter  int NCH    = 4,
    parameter  int N      = 3,
    parameter  int SETTLE = 2,
    parameter  int CONV   = 2,
    localparam int CW     = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  mux_sel,
    output logic           sample,
    input  logic [N-1:0]   adc_code,
    output logic           res_valid,
    output logic [CW-1:0]  res_ch,
    output logic [N-1:0]   res_code,
    output logic           busy
);

    // One counter is shared by SETTLE and CONVERT, so it is sized for the longer phase
    localparam int MAXC = (SETTLE > CONV) ? SETTLE : CONV;
    localparam int CNTW = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE_S = 2'd1;
    localparam logic [1:0] CONVERT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]     r_state;
    logic [CW-1:0]  r_last;
    logic [CNTW-1:0] r_cnt;
    logic [NCH-1:0] r_gnt;
    logic [CW-1:0]  r_mux_sel;
    logic           r_sample;
    logic           r_res_valid;
    logic [CW-1:0]  r_res_ch;
    logic [N-1:0]   r_res_code;
    logic           r_busy;

    logic           w_any;
    logic [CW-1:0]  w_win;
    logic [CW-1:0]  w_idx;

    // Round-robin pick: scan from last+1 upward. Walking the offsets in
    // descending order lets the nearest requester overwrite farther ones.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = NCH; i >= 1; i--) begin
            w_idx = CW'((int'(r_last) + i) % NCH);
            if (req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // Conversion sequencer. Every output is driven from a register here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= CW'(NCH - 1);
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_mux_sel   <= '0;
            r_sample    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_code  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_gnt       <= '0;
            r_sample    <= 1'b0;
            r_res_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_any) begin
                        r_state   <= SETTLE_S;
                        r_last    <= w_win;
                        r_mux_sel <= w_win;
                        r_gnt     <= NCH'(1) << w_win;
                        r_cnt     <= CNTW'(SETTLE - 1);
                        r_busy    <= 1'b1;
                    end
                end
                SETTLE_S: begin
                    if (r_cnt == '0) begin
                        r_state  <= CONVERT;
                        r_sample <= 1'b1;
                        r_cnt    <= CNTW'(CONV - 1);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                CONVERT: begin
                    if (r_cnt == '0) begin
                        r_state     <= DONE;
                        r_res_code  <= adc_code;
                        r_res_ch    <= r_mux_sel;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign mux_sel   = r_mux_sel;
    assign sample    = r_sample;
    assign res_valid = r_res_valid;
    assign res_ch    = r_res_ch;
    assign res_code  = r_res_code;
    assign busy      = r_busy;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler at default parameters.
module tb_adc_conv_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] mux_sel;
    logic       sample;
    logic [2:0] adc_code;
    logic       res_valid;
    logic [1:0] res_ch;
    logic [2:0] res_code;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    adc_conv_scheduler #(.NCH(4), .N(3), .SETTLE(2), .CONV(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .mux_sel(mux_sel),
        .sample(sample), .adc_code(adc_code), .res_valid(res_valid),
        .res_ch(res_ch), .res_code(res_code), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge: outputs then show the new cycle
    task automatic wait_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        adc_code = '0;
        repeat (2) wait_cyc();
        rst_n = 1'b1;
        wait_cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '0;
        adc_code = '0;
        #2;
        checks++;
        if ({gnt, mux_sel, sample, res_valid, res_ch, res_code, busy} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=0", {gnt, mux_sel, sample, res_valid, res_ch, res_code, busy});
        end
        repeat (2) wait_cyc();
        rst_n = 1'b1;
        wait_cyc();
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b gnt=%b want busy=0 gnt=0000", busy, gnt);
        end
    endtask

    task automatic test_single();
        logic [3:0] eg;
        do_reset();
        req = 4'b0100;
        adc_code = 3'd5;
        for (int k = 1; k <= 6; k++) begin
            wait_cyc();
            eg = (k == 1) ? 4'b0100 : 4'b0000;
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL single_gnt cycle=%0d got=%b want=%b", k, gnt, eg);
            end
            checks++;
            if (sample !== (k == 3)) begin
                failures++;
                $display("FAIL single_sample cycle=%0d got=%b want=%b", k, sample, (k == 3));
            end
            checks++;
            if (res_valid !== (k == 5)) begin
                failures++;
                $display("FAIL single_valid cycle=%0d got=%b want=%b", k, res_valid, (k == 5));
            end
            checks++;
            if (busy !== (k <= 5)) begin
                failures++;
                $display("FAIL single_busy cycle=%0d got=%b want=%b", k, busy, (k <= 5));
            end
            checks++;
            if (mux_sel !== 2'd2) begin
                failures++;
                $display("FAIL single_mux cycle=%0d got=%0d want=2", k, mux_sel);
            end
            if (k == 5) begin
                checks++;
                if (res_ch !== 2'd2 || res_code !== 3'd5) begin
                    failures++;
                    $display("FAIL single_result ch=%0d code=%0d want ch=2 code=5", res_ch, res_code);
                end
            end
            if (k == 1) req = 4'b0000;
        end
    endtask

    task automatic test_all_req();
        int exp_ch [5];
        logic [2:0] codes [4];
        logic [3:0] eg;
        exp_ch = '{0, 1, 2, 3, 0};
        codes  = '{3'd0, 3'd7, 3'd3, 3'd4};
        do_reset();
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_cyc();
            eg = 4'b0001 << exp_ch[j];
            checks++;
            if (gnt !== eg || mux_sel !== 2'(exp_ch[j])) begin
                failures++;
                $display("FAIL all_gnt conv=%0d gnt=%b mux=%0d want gnt=%b mux=%0d", j, gnt, mux_sel, eg, exp_ch[j]);
            end
            adc_code = codes[exp_ch[j]];
            repeat (4) wait_cyc();
            checks++;
            if (res_valid !== 1'b1 || res_ch !== 2'(exp_ch[j]) || res_code !== codes[exp_ch[j]]) begin
                failures++;
                $display("FAIL all_result conv=%0d v=%b ch=%0d code=%0d want v=1 ch=%0d code=%0d",
                         j, res_valid, res_ch, res_code, exp_ch[j], codes[exp_ch[j]]);
            end
            if (j == 4) req = 4'b0000;
            wait_cyc();
            checks++;
            if (busy !== 1'b0 || gnt !== 4'b0) begin
                failures++;
                $display("FAIL all_idle conv=%0d busy=%b gnt=%b want busy=0 gnt=0000", j, busy, gnt);
            end
        end
    endtask

    task automatic test_rr_sparse();
        int exp_ch [3];
        logic [3:0] eg;
        exp_ch = '{1, 3, 1};
        do_reset();
        req = 4'b1010;
        for (int j = 0; j < 3; j++) begin
            wait_cyc();
            eg = 4'b0001 << exp_ch[j];
            checks++;
            if (gnt !== eg) begin
                failures++;
                $display("FAIL rr_gnt conv=%0d got=%b want=%b", j, gnt, eg);
            end
            repeat (4) wait_cyc();
            checks++;
            if (res_valid !== 1'b1 || res_ch !== 2'(exp_ch[j])) begin
                failures++;
                $display("FAIL rr_result conv=%0d v=%b ch=%0d want v=1 ch=%0d", j, res_valid, res_ch, exp_ch[j]);
            end
            if (j == 2) req = 4'b0000;
            wait_cyc();
        end
    endtask

    task automatic test_req_change();
        do_reset();
        req = 4'b0001;
        adc_code = 3'd6;
        wait_cyc();
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL chg_gnt0 got=%b want=0001", gnt);
        end
        req = 4'b0000;
        repeat (2) wait_cyc();
        req = 4'b1000;
        checks++;
        if (mux_sel !== 2'd0 || sample !== 1'b1) begin
            failures++;
            $display("FAIL chg_convert mux=%0d sample=%b want mux=0 sample=1", mux_sel, sample);
        end
        repeat (2) wait_cyc();
        checks++;
        if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_code !== 3'd6) begin
            failures++;
            $display("FAIL chg_result v=%b ch=%0d code=%0d want v=1 ch=0 code=6", res_valid, res_ch, res_code);
        end
        wait_cyc();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL chg_idle gnt=%b busy=%b want gnt=0000 busy=0", gnt, busy);
        end
        wait_cyc();
        checks++;
        if (gnt !== 4'b1000 || mux_sel !== 2'd3) begin
            failures++;
            $display("FAIL chg_gnt1 gnt=%b mux=%0d want gnt=1000 mux=3", gnt, mux_sel);
        end
        req = 4'b0000;
        repeat (5) wait_cyc();
    endtask

    task automatic test_reset_mid();
        int seen_valid;
        do_reset();
        req = 4'b0100;
        adc_code = 3'd3;
        wait_cyc();
        req = 4'b0000;
        repeat (2) wait_cyc();
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, mux_sel, sample, res_valid, res_ch, res_code, busy} !== 15'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%b want=0", {gnt, mux_sel, sample, res_valid, res_ch, res_code, busy});
        end
        seen_valid = 0;
        repeat (2) begin
            wait_cyc();
            if (res_valid) seen_valid++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            wait_cyc();
            if (res_valid) seen_valid++;
        end
        checks++;
        if (seen_valid != 0) begin
            failures++;
            $display("FAIL mid_no_valid got=%0d want=0", seen_valid);
        end
        req = 4'b1111;
        wait_cyc();
        checks++;
        if (gnt !== 4'b0001 || mux_sel !== 2'd0) begin
            failures++;
            $display("FAIL mid_regrant gnt=%b mux=%0d want gnt=0001 mux=0", gnt, mux_sel);
        end
        req = 4'b0000;
        repeat (5) wait_cyc();
    endtask

    task automatic test_code_hold();
        do_reset();
        req = 4'b0010;
        adc_code = 3'd6;
        wait_cyc();
        req = 4'b0000;
        repeat (4) wait_cyc();
        adc_code = 3'd1;
        for (int k = 5; k <= 7; k++) begin
            checks++;
            if (res_code !== 3'd6 || res_ch !== 2'd1) begin
                failures++;
                $display("FAIL hold_code cycle=%0d code=%0d ch=%0d want code=6 ch=1", k, res_code, res_ch);
            end
            wait_cyc();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_req();
        test_rr_sparse();
        test_req_change();
        test_reset_mid();
        test_code_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_conv_scheduler.md
# adc_conv_scheduler

Round-robin conversion scheduler that shares one N-bit ADC among NCH requesters. For each conversion it grants one requester, drives the analog input mux select, waits a programmable settling time, pulses the ADC sample strobe, waits the conversion latency, captures the ADC output code, and returns it tagged with the channel number. It sits between the requesting digital blocks and the ADC macro and owns the ADC's sampling schedule.

## Interface
- NCH, 4: number of requesters, at least 2
- N, 3: ADC code width
- SETTLE, 2: mux settling cycles, at least 1
- CONV, 2: ADC conversion latency in cycles, measured from the sample pulse; at least 1
- CW, $clog2(NCH): channel index width (derived)

- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NCH  per-channel level request
- gnt  out  NCH  one-hot grant, one-cycle pulse
- mux_sel  out  CW  analog mux select for the ADC input
- sample  out  1  ADC sample strobe, one-cycle pulse
- adc_code  in  N  ADC output code
- res_valid  out  1  result strobe, one-cycle pulse
- res_ch  out  CW  channel of the current result
- res_code  out  N  captured code
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETTLE, CONVERT, DONE.
- IDLE: if any req bit is set, pick the winner round-robin, register it into mux_sel, pulse gnt for the winner, go to SETTLE. If no req bit is set, stay in IDLE.
- Round-robin rule: search starts at last+1, modulo NCH. After reset, last = NCH-1, so channel 0 has top priority.
- SETTLE: run for exactly SETTLE cycles, then go to CONVERT.
- CONVERT: sample is high during the first CONVERT cycle only. Run for exactly CONV cycles. At the final edge of CONVERT:
  - latch adc_code into res_code;
  - latch mux_sel into res_ch;
  - go to DONE.
- DONE: res_valid high for one cycle, then go to IDLE.
- mux_sel is stable from the grant edge through DONE. It holds its value in IDLE.
- res_ch and res_code hold their values until the next capture.
- A single cycle-counter, at least clog2(max(SETTLE,CONV)+1) bits, is reused by SETTLE and CONVERT. It reloads on every state entry.
- req is sampled only in IDLE. Changes to req during SETTLE, CONVERT or DONE are ignored; a conversion in progress always completes.
- A requester that keeps req high after its grant is treated as a new request and takes its turn in the rotation.
- res_code is the raw ADC code, width N. It is not modified or saturated.

## Timing
- Reset: takes effect immediately regardless of clk. State goes to IDLE, last = NCH-1, counter = 0.
- Reset values of outputs: gnt = 0, mux_sel = 0, sample = 0, res_valid = 0, res_ch = 0, res_code = 0, busy = 0.
- Reset mid-operation aborts the conversion. No res_valid is produced.
- Cycle numbering: the grant edge is edge 0, and cycle k follows edge k-1.
  - gnt is high and busy rises in cycle 1.
  - SETTLE occupies cycles 1..SETTLE.
  - sample is high in cycle SETTLE+1.
  - adc_code is captured at the end of cycle SETTLE+CONV.
  - res_valid is high in cycle SETTLE+CONV+1.
  - The FSM is back in IDLE in cycle SETTLE+CONV+2.
- Grant-to-result latency is SETTLE+CONV cycles.
- Back-to-back grant spacing is SETTLE+CONV+2 cycles; with the defaults this is 6.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Formal properties:
  - gnt is one-hot or zero;
  - sample and res_valid each pulse exactly once per grant;
  - mux_sel is stable between gnt and res_valid;
  - res_ch equals the index of the last gnt whenever res_valid is high;
  - every channel holding req continuously is granted within NCH·(SETTLE+CONV+2) cycles.

## Test plan
All scenarios use the defaults (NCH=4, N=3, SETTLE=2, CONV=2).
- Reset, then req=4'b0100 for one cycle, adc_code=3'd5 → gnt=4'b0100 in cycle 1, mux_sel=2 in cycles 1–5, sample in cycle 3, res_valid in cycle 5 with res_ch=2 and res_code=5.
- req=4'b1111 held → grants go 0,1,2,3,0 at 6-cycle spacing. res_code tracks adc_code driven as 0,7,3,4 per channel (boundary codes 0 and 7 exact).
- Reset, then req=4'b1010 → channel 1 is granted first, then channel 3, then channel 1 again.
- req dropped in the cycle after gnt, and a different req raised during CONVERT → the first conversion completes unchanged and the new channel is granted from IDLE in cycle 6.
- rst_n pulsed low during CONVERT → all outputs are 0 immediately, no res_valid appears, and the next request gets its first gnt exactly as after a fresh reset.
- adc_code changed in cycle 5, after capture → res_code keeps the value captured at the end of cycle 4.
